// File: rtl/flt2int_seq.sv
// rtl/flt2int_seq.sv - sequential half-precision float to sign-magnitude integer converter
//
// Reads a 16-bit half-precision operand from data memory as two bytes, aligns the
// mantissa with a one-bit-per-cycle shifter, rounds, and writes a 16-bit
// sign-magnitude result back as two bytes.
//
// Build option: define FLT2INT_ROUND_EN for round-to-nearest-even; otherwise the
// ROUND state truncates toward zero (the state is kept so latency is identical).
//
// Parameters:
//   IN_ADDR      operand address (high byte at IN_ADDR, low byte at IN_ADDR+1)
//   OUT_ADDR     result address  (high byte at OUT_ADDR, low byte at OUT_ADDR+1)
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-low reset
//   req          start request, accepted in IDLE and DONE
//   done         high in DONE until the next accepted request
//   mem_addr     data-memory address
//   mem_rd_data  combinational read data for mem_addr
//   mem_wr_en    write strobe (WR_HI and WR_LO only)
//   mem_wr_data  write data

module flt2int_seq #(
  parameter logic [7:0] IN_ADDR  = 8'd4,
  parameter logic [7:0] OUT_ADDR = 8'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    ALIGN,
    ROUND,
    WR_HI,
    WR_LO,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Operand high byte: sign, exponent and top two mantissa bits. The sign is
  // taken from here all the way to the final write.
  logic [7:0]  hi_byte;
  // Magnitude being aligned; 15 bits hold the largest finite result (0x7FF0).
  logic [14:0] mag;
  logic        guard;
  logic        sticky;
  logic [3:0]  shift_cnt;
  logic        shift_left;
  logic        is_zero;
  logic        is_sat;

  logic [4:0]  exp_w;
  logic [3:0]  n_w;
  logic        left_w;
  logic        hidden_w;
  logic [14:0] round_mag;
  logic [15:0] result;

  assign exp_w    = hi_byte[6:2];
  assign hidden_w = (exp_w != 5'd0);
  assign result   = {hi_byte[7], mag};

  // Shift count decode. value = {1,mant} * 2^(exp-25), so exp 25 needs no shift.
  // Right shifts are capped at 12: beyond that the 11-bit mantissa lies wholly
  // in the sticky bit and the guard bit is already zero, so the result is 0.
  always_comb begin
    n_w    = 4'd0;
    left_w = 1'b0;
    if (exp_w == 5'd0 || exp_w >= 5'd30 || exp_w == 5'd25) begin
      n_w = 4'd0;
    end else if (exp_w > 5'd25) begin
      n_w    = 4'(exp_w - 5'd25);
      left_w = 1'b1;
    end else if (exp_w <= 5'd13) begin
      n_w = 4'd12;
    end else begin
      n_w = 4'(5'd25 - exp_w);
    end
  end

  // Rounding. Incrementing cannot overflow 15 bits: right-shifted magnitudes
  // are at most 0x3FF, and left-shifted ones are exact (guard = sticky = 0).
  always_comb begin
    round_mag = mag;
    if (is_sat) begin
      round_mag = 15'h7FFF;
    end else if (is_zero) begin
      round_mag = 15'd0;
    end else begin
`ifdef FLT2INT_ROUND_EN
      round_mag = mag + 15'(guard & (sticky | mag[0]));
`else
      round_mag = mag;
`endif
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_next  = state;
    done        = 1'b0;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state)
      IDLE: begin
        if (req) state_next = RD_HI;
      end
      RD_HI: begin
        mem_addr   = IN_ADDR;
        state_next = RD_LO;
      end
      RD_LO: begin
        mem_addr   = IN_ADDR + 8'd1;
        state_next = (n_w != 4'd0) ? ALIGN : ROUND;
      end
      ALIGN: begin
        if (shift_cnt == 4'd1) state_next = ROUND;
      end
      ROUND: begin
        state_next = WR_HI;
      end
      WR_HI: begin
        mem_addr    = OUT_ADDR;
        mem_wr_en   = 1'b1;
        mem_wr_data = result[15:8];
        state_next  = WR_LO;
      end
      WR_LO: begin
        mem_addr    = OUT_ADDR + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = result[7:0];
        state_next  = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (req) state_next = RD_HI;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      hi_byte    <= 8'd0;
      mag        <= 15'd0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      shift_cnt  <= 4'd0;
      shift_left <= 1'b0;
      is_zero    <= 1'b0;
      is_sat     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        RD_HI: begin
          hi_byte <= mem_rd_data;
        end
        RD_LO: begin
          mag        <= {4'd0, hidden_w, hi_byte[1:0], mem_rd_data};
          guard      <= 1'b0;
          sticky     <= 1'b0;
          shift_cnt  <= n_w;
          shift_left <= left_w;
          is_zero    <= (exp_w == 5'd0);
          is_sat     <= (exp_w >= 5'd30);
        end
        ALIGN: begin
          if (shift_left) begin
            mag <= {mag[13:0], 1'b0};
          end else begin
            // Old guard folds into sticky; the bit shifted out becomes guard.
            mag    <= {1'b0, mag[14:1]};
            guard  <= mag[0];
            sticky <= sticky | guard;
          end
          shift_cnt <= shift_cnt - 4'd1;
        end
        ROUND: begin
          mag <= round_mag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2int_seq.sv
// tb/tb_flt2int_seq.sv - self-checking bench for flt2int_seq with memory model and result scoreboard

module tb_flt2int_seq;

  localparam logic [7:0] IN_ADDR  = 8'd4;
  localparam logic [7:0] OUT_ADDR = 8'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] mem [0:255];
  int         wr_cnt = 0;
  int         bad_wr = 0;
  int         checks = 0;
  int         failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  flt2int_seq #(.IN_ADDR(IN_ADDR), .OUT_ADDR(OUT_ADDR)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .done(done),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      if (mem_addr == OUT_ADDR || mem_addr == OUT_ADDR + 8'd1) wr_cnt++;
      else bad_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference conversion written from the numeric definition:
  // value = {1,mant} * 2^(exp-25), rounded by quotient/remainder.
  function automatic logic [15:0] model(input logic [15:0] op);
    int e, m, s, q, rem, half;
    logic [14:0] mg;
    e = int'(op[14:10]);
    m = 1024 + int'(op[9:0]);
    if (e == 0) mg = 15'd0;
    else if (e >= 30) mg = 15'h7FFF;
    else if (e >= 25) mg = 15'(m << (e - 25));
    else begin
      s = 25 - e;
      q = m >> s;
      rem = m - (q << s);
      half = 1 << (s - 1);
`ifdef FLT2INT_ROUND_EN
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
`endif
      mg = 15'(q);
    end
    return {op[15], mg};
  endfunction

  function automatic int model_lat(input logic [15:0] op);
    int e;
    e = int'(op[14:10]);
    if (e == 0 || e >= 30 || e == 25) return 5;
    if (e > 25) return e - 25 + 5;
    if (25 - e > 12) return 12 + 5;
    return 25 - e + 5;
  endfunction

  // Run one conversion starting from IDLE or DONE. Optionally pulse req
  // mid-flight (pulse_at > 0) to confirm it is ignored.
  task automatic do_conv(input string tag, input logic [15:0] op, input logic [15:0] expv,
                         input int exp_lat, input int pulse_at);
    int cycles;
    int wr0;
    logic [15:0] got, want;
    mem[IN_ADDR]        = op[15:8];
    mem[IN_ADDR + 8'd1] = op[7:0];
    exp_q.push_back(expv);
    wr0 = wr_cnt;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    cycles = 0;
    while (!done && cycles < 100) begin
      if (pulse_at > 0 && cycles == pulse_at) req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      cycles++;
    end
    check({tag, "_latency"}, cycles, exp_lat);
    want = exp_q.pop_front();
    got  = {mem[OUT_ADDR], mem[OUT_ADDR + 8'd1]};
    check({tag, "_result"}, {16'd0, got}, {16'd0, want});
    check({tag, "_writes"}, wr_cnt - wr0, 2);
  endtask

  initial begin
    logic [15:0] r;
    int wr_save;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    reset = 1'b0;
    req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
    req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_conv("one",   16'h3C00, 16'h0001, 15, 0);
`ifdef FLT2INT_ROUND_EN
    do_conv("one_p5", 16'h3E00, 16'h0002, 15, 0);
`else
    do_conv("one_p5", 16'h3E00, 16'h0001, 15, 0);
`endif
    do_conv("half",  16'h3800, 16'h0000, 16, 0);
    do_conv("neg5",  16'hC500, 16'h8005, 13, 0);
    do_conv("exp29", 16'h77FF, 16'h7FF0, 9, 0);
    do_conv("ovf",   16'h7800, 16'h7FFF, 5, 0);
    do_conv("ninf",  16'hFC00, 16'hFFFF, 5, 0);
    do_conv("denorm", 16'h0001, 16'h0000, 5, 0);
    do_conv("neg0p4", 16'hB666, 16'h8000, 17, 0);
    do_conv("exp25", 16'h6400, 16'h0400, 5, 0);

    // Reset during ALIGN: no write may reach OUT_ADDR.
    mem[OUT_ADDR]        = 8'hAA;
    mem[OUT_ADDR + 8'd1] = 8'hAA;
    mem[IN_ADDR]         = 8'h3C;
    mem[IN_ADDR + 8'd1]  = 8'h00;
    wr_save = wr_cnt;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_addr", {24'd0, mem_addr}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_idle_done", {31'd0, done}, 32'd0);
    check("abort_writes", wr_cnt - wr_save, 0);
    check("abort_mem", {24'd0, mem[OUT_ADDR]}, 32'h0000_00AA);
    do_conv("fresh", 16'h4900, 16'h000A, 12, 0);

    // req pulsed during ALIGN is ignored; then req in DONE restarts.
    do_conv("ign_req", 16'hC500, 16'h8005, 13, 4);
    do_conv("restart", 16'h3C00, 16'h0001, 15, 0);

    for (int i = 0; i < 8; i++) begin
      r = 16'($urandom);
      do_conv("rand", r, model(r), model_lat(r), 0);
    end

    check("stray_writes", bad_wr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
